// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits, odd parity, stop, ACK.
// Drives active-high pull-low enables for the open-drain clock and data lines.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRts,
    StFrame,
    StWaitIdle
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      clk_sync_q;
  logic [1:0]      data_sync_q;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            clk_oe_q, clk_oe_d;
  logic            data_oe_q, data_oe_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic            clk_s;
  logic            data_s;
  logic            fall;
  logic            tmo_hit;
  logic [3:0]      fall_idx;

  // Bus idles high, so the synchronisers reset to 1 and cannot fake a fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= 3'b111;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk_in};
      data_sync_q <= {data_sync_q[0], ps2_data_in};
    end
  end

  assign clk_s    = clk_sync_q[1];
  assign data_s   = data_sync_q[1];
  assign fall     = clk_sync_q[2] & ~clk_sync_q[1];
  assign tmo_hit  = (tmo_cnt_q == TmoLast);
  assign fall_idx = bit_cnt_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (tx_start) begin
          shift_d   = tx_data;
          parity_d  = ~^tx_data;
          bit_cnt_d = '0;
          inh_cnt_d = '0;
          busy_d    = 1'b1;
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
          state_d   = StInhibit;
        end
      end

      StInhibit: begin
        if (inh_cnt_q == InhLast) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          tmo_cnt_d = '0;
          state_d   = StRts;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end

      StRts, StFrame: begin
        if (tmo_hit) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          busy_d    = 1'b0;
          error_d   = 1'b1;
          state_d   = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (fall) begin
            bit_cnt_d = fall_idx;
            state_d   = StFrame;
            if (fall_idx <= 4'd8) begin
              // Data bits leave LSB first off the bottom of the shift register.
              data_oe_d = ~shift_q[0];
              shift_d   = {1'b0, shift_q[7:1]};
            end else if (fall_idx == 4'd9) begin
              data_oe_d = ~parity_q;
            end else if (fall_idx == 4'd10) begin
              data_oe_d = 1'b0;
            end else if (data_s) begin
              data_oe_d = 1'b0;
              busy_d    = 1'b0;
              error_d   = 1'b1;
              state_d   = StIdle;
            end else begin
              state_d   = StWaitIdle;
            end
          end
        end
      end

      StWaitIdle: begin
        if (tmo_hit) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          busy_d    = 1'b0;
          error_d   = 1'b1;
          state_d   = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (clk_s && data_s) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      tmo_cnt_q <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model on open-drain lines, a frame model built from
// the byte by bit counting, and a per-cycle monitor for line/pulse invariants.
module tb_ps2_host_tx;

  localparam int unsigned InhCycles = 20;
  localparam int unsigned TmoCycles = 2000;
  localparam int unsigned HalfPer   = 20;

  logic       clk;
  logic       rst;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       done;
  logic       error;
  logic       dev_clk_low;
  logic       dev_data_low;

  int vectors     = 0;
  int miscompares = 0;

  // Monitor state, written only by the negedge monitor.
  int         cyc        = 0;
  int         inh_run    = 0;
  int         last_inh   = 0;
  int         rts_cyc    = 0;
  int         err_cyc    = 0;
  int         done_cnt   = 0;
  int         err_cnt    = 0;
  int         busy_rises = 0;
  logic       rts_data   = 1'b0;
  logic       prev_busy  = 1'b0;
  logic [1:0] err_oe     = 2'b00;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(InhCycles),
    .TIMEOUT_CYCLES(TmoCycles)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected wire frame, bit k = k-th device sample: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    int   ones;
    logic par;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    par = ((ones % 2) == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b, 1'b0};
  endfunction

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (ps2_clk_oe) begin
      inh_run <= inh_run + 1;
    end else begin
      if (inh_run != 0) begin
        last_inh <= inh_run;
        rts_cyc  <= cyc;
        rts_data <= ps2_data_oe;
      end
      inh_run <= 0;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (error) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
      err_oe  <= {ps2_clk_oe, ps2_data_oe};
    end
    if (busy && !prev_busy) busy_rises <= busy_rises + 1;
    prev_busy <= busy;
    if (!rst) begin
      check("done_error_exclusive", {31'd0, done & error}, 32'd0);
      check("oe_not_both", {31'd0, ps2_clk_oe & ps2_data_oe}, 32'd0);
      if (!busy) check("idle_lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    end
  end

  // mode: 0 ACK, 1 NACK, 2 silent after RTS, 3 stop after 4th fall holding clock low,
  // 4 ACK with a colliding 0xAA request mid-frame.
  task automatic send(input logic [7:0] b, input int mode, output logic [10:0] frame);
    int t;
    frame    = '0;
    tx_data  = b;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    tx_data  = 8'h00;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    t = 0;
    while (!(ps2_clk_in && !ps2_data_in) && t < 500) begin
      tick();
      t++;
    end
    check("rts_seen", {31'd0, (t < 500)}, 32'd1);
    if (mode == 2) return;
    frame[0] = ps2_data_in;
    for (int k = 1; k <= 10; k++) begin
      repeat (HalfPer) tick();
      if (mode == 4 && k == 5) begin
        tx_data  = 8'hAA;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        tx_data  = 8'h00;
      end
      dev_clk_low = 1'b1;
      if (mode == 3 && k == 4) begin
        repeat (10) tick();
        return;
      end
      repeat (HalfPer) tick();
      dev_clk_low = 1'b0;
      tick();
      frame[k] = ps2_data_in;
    end
    repeat (HalfPer) tick();
    dev_data_low = (mode != 1);
    repeat (HalfPer) tick();
    dev_clk_low = 1'b1;
    repeat (HalfPer) tick();
    dev_clk_low = 1'b0;
    repeat (HalfPer) tick();
    dev_data_low = 1'b0;
  endtask

  task automatic do_xfer(input logic [7:0] b, input int mode, input logic [10:0] lit);
    int         d0;
    int         e0;
    int         b0;
    int         t;
    logic [10:0] fr;
    d0 = done_cnt;
    e0 = err_cnt;
    b0 = busy_rises;
    send(b, mode, fr);
    t = 0;
    while (done_cnt == d0 && err_cnt == e0 && t < 3000) begin
      tick();
      t++;
    end
    repeat (60) tick();
    check("inhibit_len", last_inh, InhCycles);
    check("rts_data_low", {31'd0, rts_data}, 32'd1);
    check("accept_count", busy_rises - b0, 32'd1);
    check("busy_after_end", {31'd0, busy}, 32'd0);
    if (mode == 2) begin
      check("timeout_error", err_cnt - e0, 32'd1);
      check("timeout_no_done", done_cnt - d0, 32'd0);
      check("timeout_latency", err_cyc - rts_cyc, TmoCycles);
      check("timeout_lines", {30'd0, err_oe}, 32'd0);
    end else begin
      check("frame_model", {21'd0, fr}, {21'd0, model_frame(b)});
      check("frame_literal", {21'd0, fr}, {21'd0, lit});
      check("done_pulses", done_cnt - d0, (mode == 1) ? 32'd0 : 32'd1);
      check("error_pulses", err_cnt - e0, (mode == 1) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    logic [10:0] fr;
    int          d0;
    int          e0;
    rst          = 1'b1;
    tx_start     = 1'b0;
    tx_data      = 8'h00;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) tick();
    check("rst_outputs", {27'd0, ps2_clk_oe, ps2_data_oe, busy, done, error}, 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("post_rst_outputs", {27'd0, ps2_clk_oe, ps2_data_oe, busy, done, error}, 32'd0);

    do_xfer(8'hED, 0, 11'h7DA);
    do_xfer(8'hF4, 0, 11'h5E8);
    do_xfer(8'h00, 0, 11'h600);
    do_xfer(8'hED, 1, 11'h7DA);
    do_xfer(8'hF4, 0, 11'h5E8);
    do_xfer(8'hF4, 2, 11'h000);
    do_xfer(8'hED, 4, 11'h7DA);

    d0 = done_cnt;
    e0 = err_cnt;
    send(8'hED, 3, fr);
    check("busy_mid_frame", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", {29'd0, ps2_clk_oe, ps2_data_oe, busy}, 32'd0);
    dev_clk_low = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    check("rst_mid_no_done", done_cnt - d0, 32'd0);
    check("rst_mid_no_error", err_cnt - e0, 32'd0);
    do_xfer(8'hFF, 0, 11'h7FE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter; the sending end of the keyboard link whose device-to-host bytes are received by the PS/2 receiver.
- Sends one command byte per request to the keyboard: inhibit, request-to-send, 8 data bits, odd parity, stop, device ACK. Typical bytes: 0xED set-LEDs, 0xF4 enable, 0xFF reset.
- Drives the open-drain PS/2 clock and data lines via active-high pull-low enables. The top level builds the tri-states.
- While busy is high, the top level masks the receiver.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles the PS/2 clock is held low before request-to-send (100 us at 50 MHz); minimum 2
TIMEOUT_CYCLES, 750000, clk cycles allowed from clock release to ACK sampled (15 ms at 50 MHz)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  asynchronous active-high reset
ps2_clk_in  input  1  raw PS/2 clock line level (asynchronous)
ps2_data_in  input  1  raw PS/2 data line level (asynchronous)
ps2_clk_oe  output  1  1 = pull PS/2 clock low
ps2_data_oe  output  1  1 = pull PS/2 data low
tx_data  input  8  byte to send; sampled on the accept cycle
tx_start  input  1  send request; single-cycle or level
busy  output  1  transfer in progress
done  output  1  one-cycle pulse: byte sent and ACK (data=0) received
error  output  1  one-cycle pulse: timeout or NACK (ACK bit = 1)

Behaviour:
- Reset: asynchronous; all outputs 0, lines released, state IDLE, counters 0. Reset during a transfer releases both lines at once and aborts with no done/error pulse.
- Input sync:
  - ps2_clk_in and ps2_data_in each pass through 2-flop synchronisers; 3rd flop on clock for edge detect.
  - fall = prev 1 and current 0 on the synchronised clock.
- Accept: in IDLE with tx_start=1, latch tx_data, compute parity = ~^tx_data, set busy=1 next cycle. tx_start while busy is ignored; no queueing.
- INHIBIT:
  - ps2_clk_oe=1, ps2_data_oe=0 for INHIBIT_CYCLES cycles.
  - In the last inhibit cycle the next state is RTS.
- RTS:
  - ps2_data_oe=1 (start bit 0), ps2_clk_oe=0; timeout counter cleared and starts.
  - Wait for fall.
- Falling-edge sequence, with the output updated the cycle after fall is detected. Fall index n counts from 1:
  - n=1..8: ps2_data_oe = ~tx_data[n-1] (LSB first).
  - n=9: ps2_data_oe = ~parity.
  - n=10: ps2_data_oe=0 (stop bit, line released).
  - n=11: sample synchronised data. 0 = ACK, 1 = NACK.
- After ACK: go to WAIT_IDLE until synchronised clock=1 and data=1. Then pulse done for 1 cycle, busy=0 the same cycle, return to IDLE.
- After NACK: pulse error, busy=0, IDLE. No wait on the bus.
- Timeout:
  - Counter runs from RTS entry through ACK sample; it is not reset per edge.
  - On reaching TIMEOUT_CYCLES: release both lines, pulse error, busy=0, IDLE.
  - WAIT_IDLE is also covered by the same counter; timeout there yields error, not done.
- Exclusivity: done and error are never high together. busy is high from the cycle after accept through the cycle before the done/error pulse.
- Bit counter is 4 bits; no wrap is reachable since the sequence ends at 11.
- Width: timeout counter is sized $clog2(TIMEOUT_CYCLES+1); inhibit counter is sized $clog2(INHIBIT_CYCLES+1).

Test Plan:
Bench uses INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000, and a device model clocking at 1/40 clk.
- Send 0xED:
  - ps2_clk_oe low for exactly 20 cycles, then data driven low.
  - Device samples on rising edges: 0 (start), 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - ACK 0 -> done pulse once, busy falls, no error.
- Send 0xF4: data bits 0,0,1,0,1,1,1,1, parity 0 -> done. Send 0x00: parity 1 -> done.
- NACK: device drives data=1 at the 11th fall -> error pulse, done stays 0, lines released, next tx_start accepted.
- Timeout: device never clocks after RTS -> error exactly 2000 cycles after RTS entry, both oe = 0.
- Busy collision: tx_start with tx_data=0xAA during a 0xED transfer -> ignored; only 0xED bits appear on the wire.
- Reset mid-transfer: rst asserted after the 4th fall -> ps2_clk_oe = ps2_data_oe = busy = 0 immediately with no done/error; a new 0xFF request after rst deassert completes with done.
